// File: rtl/memory2_stage_if.sv
// Memory1 -> Memory2 -> Writeback signal bundle. The stage itself uses the
// slave modport; whatever drives Memory1 and Writeback uses the master modport.
interface memory2_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] ex_result_pass;
  logic [4:0]      rd_index_pass;
  logic [2:0]      number_length_pass;
  logic [1:0]      memory_rw_pass;
  logic            writeback_valid_pass;
  logic            writeback_src_pass;
  logic            dcache_data_ok;
  logic [XLEN-1:0] dcache_rdata;
  logic            wb_valid;
  logic            wb_ready;
  logic            wb_en;
  logic [4:0]      wb_rd_index;
  logic [XLEN-1:0] wb_data;

  modport slave (
    input  flush, in_valid, ex_result_pass, rd_index_pass, number_length_pass,
           memory_rw_pass, writeback_valid_pass, writeback_src_pass,
           dcache_data_ok, dcache_rdata, wb_ready,
    output in_ready, wb_valid, wb_en, wb_rd_index, wb_data
  );

  modport master (
    output flush, in_valid, ex_result_pass, rd_index_pass, number_length_pass,
           memory_rw_pass, writeback_valid_pass, writeback_src_pass,
           dcache_data_ok, dcache_rdata, wb_ready,
    input  in_ready, wb_valid, wb_en, wb_rd_index, wb_data
  );
endinterface

// File: rtl/memory2_stage.sv
// Memory2 pipeline stage: waits for the data-cache response, formats load
// data and holds a registered result for Writeback under valid/ready.
//
// state | meaning
// IDLE  | stage empty, ready to accept
// WAIT  | load/store accepted, cache response outstanding
// DONE  | result held for Writeback
// DRAIN | flushed while a response is outstanding; swallow it
module memory2_stage #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  memory2_stage_if.slave   bus_io
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] ex_result_q, ex_result_d;
  logic [4:0]      rd_index_q, rd_index_d;
  logic [2:0]      len_q, len_d;
  logic [1:0]      rw_q, rw_d;
  logic            wbv_q, wbv_d;
  logic            src_q, src_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic            in_ready;
  logic            accept;
  logic            in_is_mem;
  logic            is_load;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic            sext;
  logic [XLEN-1:0] load_fmt;

  assign in_ready  = ~bus_io.flush &
                     ((state_q == IDLE) | ((state_q == DONE) & bus_io.wb_ready));
  assign accept    = bus_io.in_valid & in_ready;
  assign in_is_mem = (bus_io.memory_rw_pass == 2'b01) | (bus_io.memory_rw_pass == 2'b10);
  assign is_load   = (rw_q == 2'b01);
  assign sext      = ~len_q[2];

  always_comb begin
    byte_sel = 8'h00;
    case (ex_result_q[1:0])
      2'd0: byte_sel = bus_io.dcache_rdata[7:0];
      2'd1: byte_sel = bus_io.dcache_rdata[15:8];
      2'd2: byte_sel = bus_io.dcache_rdata[23:16];
      2'd3: byte_sel = bus_io.dcache_rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = ex_result_q[1] ? bus_io.dcache_rdata[31:16] : bus_io.dcache_rdata[15:0];
    case (len_q[1:0])
      2'b00:   load_fmt = {{24{sext & byte_sel[7]}}, byte_sel};
      2'b01:   load_fmt = {{16{sext & half_sel[15]}}, half_sel};
      default: load_fmt = bus_io.dcache_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ex_result_d = ex_result_q;
    rd_index_d  = rd_index_q;
    len_d       = len_q;
    rw_d        = rw_q;
    wbv_d       = wbv_q;
    src_d       = src_q;
    wb_data_d   = wb_data_q;

    if (bus_io.flush) begin
      case (state_q)
        WAIT:    state_d = bus_io.dcache_data_ok ? IDLE : DRAIN;
        DRAIN:   state_d = DRAIN;
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        WAIT: begin
          if (bus_io.dcache_data_ok) begin
            state_d   = DONE;
            wb_data_d = (is_load & src_q) ? load_fmt : ex_result_q;
          end
        end
        DONE: begin
          if (bus_io.wb_ready & ~accept) state_d = IDLE;
        end
        DRAIN: begin
          if (bus_io.dcache_data_ok) state_d = IDLE;
        end
        default: ;
      endcase

      // accept overrides the DONE->IDLE path for zero-bubble back-to-back
      if (accept) begin
        state_d     = in_is_mem ? WAIT : DONE;
        ex_result_d = bus_io.ex_result_pass;
        rd_index_d  = bus_io.rd_index_pass;
        len_d       = bus_io.number_length_pass;
        rw_d        = bus_io.memory_rw_pass;
        wbv_d       = bus_io.writeback_valid_pass;
        src_d       = bus_io.writeback_src_pass;
        wb_data_d   = bus_io.ex_result_pass;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ex_result_q <= '0;
      rd_index_q  <= '0;
      len_q       <= '0;
      rw_q        <= '0;
      wbv_q       <= 1'b0;
      src_q       <= 1'b0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      ex_result_q <= ex_result_d;
      rd_index_q  <= rd_index_d;
      len_q       <= len_d;
      rw_q        <= rw_d;
      wbv_q       <= wbv_d;
      src_q       <= src_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign bus_io.in_ready    = in_ready;
  assign bus_io.wb_valid    = (state_q == DONE);
  assign bus_io.wb_en       = (state_q == DONE) & wbv_q & (rd_index_q != 5'd0);
  assign bus_io.wb_rd_index = rd_index_q;
  assign bus_io.wb_data     = wb_data_q;

endmodule

// File: tb/tb_memory2_stage.sv
// Directed self-checking bench for memory2_stage: ALU pass-through, load
// formatting, writeback stall, flush/drain and reset during an access.
module tb_memory2_stage;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  memory2_stage_if bus ();

  memory2_stage dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] ex, input logic [4:0] rd, input logic [2:0] len,
                        input logic [1:0] rw, input logic wbv, input logic src);
    bus.in_valid             = 1'b1;
    bus.ex_result_pass       = ex;
    bus.rd_index_pass        = rd;
    bus.number_length_pass   = len;
    bus.memory_rw_pass       = rw;
    bus.writeback_valid_pass = wbv;
    bus.writeback_src_pass   = src;
  endtask

  task automatic accept_op(input logic [31:0] ex, input logic [4:0] rd, input logic [2:0] len,
                           input logic [1:0] rw, input logic wbv, input logic src);
    set_op(ex, rd, len, rw, wbv, src);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_ok(input logic [31:0] rdata);
    bus.dcache_data_ok = 1'b1;
    bus.dcache_rdata   = rdata;
    tick();
    bus.dcache_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_checks++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got %b want 0", bus.wb_valid); end
    n_checks++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en got %b want 0", bus.wb_en); end
    n_checks++; if (bus.wb_rd_index !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0d want 0", bus.wb_rd_index); end
    n_checks++; if (bus.wb_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.wb_data); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    set_op(32'h1234_5678, 5'd5, 3'b010, 2'b00, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL alu_in_ready_idle got %b want 1", bus.in_ready); end
    tick();
    n_checks++; if (bus.wb_valid !== 1'b1) begin n_fail++; $display("FAIL alu_wb_valid got %b want 1", bus.wb_valid); end
    n_checks++; if (bus.wb_en !== 1'b1) begin n_fail++; $display("FAIL alu_wb_en got %b want 1", bus.wb_en); end
    n_checks++; if (bus.wb_rd_index !== 5'd5) begin n_fail++; $display("FAIL alu_rd got %0d want 5", bus.wb_rd_index); end
    n_checks++; if (bus.wb_data !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_data got %h want 12345678", bus.wb_data); end
    // second op presented while first is handed over; rw=11 behaves as no access
    set_op(32'hAABB_CCDD, 5'd6, 3'b010, 2'b11, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL alu_b2b_in_ready got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.wb_valid !== 1'b1) begin n_fail++; $display("FAIL alu_b2b_valid got %b want 1", bus.wb_valid); end
    n_checks++; if (bus.wb_data !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL alu_b2b_data got %h want aabbccdd", bus.wb_data); end
    n_checks++; if (bus.wb_rd_index !== 5'd6) begin n_fail++; $display("FAIL alu_b2b_rd got %0d want 6", bus.wb_rd_index); end
    tick();
    n_checks++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_idle_valid got %b want 0", bus.wb_valid); end
  endtask

  task automatic test_load_byte();
    accept_op(32'h1000_0003, 5'd3, 3'b000, 2'b01, 1'b1, 1'b1);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL lb_wait_in_ready got %b want 0", bus.in_ready); end
    n_checks++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL lb_wait_valid got %b want 0", bus.wb_valid); end
    tick();
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL lb_wait2_in_ready got %b want 0", bus.in_ready); end
    pulse_ok(32'h80FF_0102);
    n_checks++; if (bus.wb_valid !== 1'b1) begin n_fail++; $display("FAIL lb_valid got %b want 1", bus.wb_valid); end
    n_checks++; if (bus.wb_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_signed got %h want ffffff80", bus.wb_data); end
    tick();
    accept_op(32'h1000_0003, 5'd3, 3'b100, 2'b01, 1'b1, 1'b1);
    tick();
    pulse_ok(32'h80FF_0102);
    n_checks++; if (bus.wb_data !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu got %h want 00000080", bus.wb_data); end
    tick();
    accept_op(32'h1000_0001, 5'd3, 3'b000, 2'b01, 1'b1, 1'b1);
    pulse_ok(32'h80FF_0102);
    n_checks++; if (bus.wb_data !== 32'h0000_0001) begin n_fail++; $display("FAIL lb_lane1 got %h want 00000001", bus.wb_data); end
    tick();
  endtask

  task automatic test_load_half_word();
    accept_op(32'h1000_0002, 5'd4, 3'b001, 2'b01, 1'b1, 1'b1);
    pulse_ok(32'h8001_7FFF);
    n_checks++; if (bus.wb_data !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_hi got %h want ffff8001", bus.wb_data); end
    tick();
    accept_op(32'h1000_0000, 5'd4, 3'b101, 2'b01, 1'b1, 1'b1);
    pulse_ok(32'h8001_7FFF);
    n_checks++; if (bus.wb_data !== 32'h0000_7FFF) begin n_fail++; $display("FAIL lhu_lo got %h want 00007fff", bus.wb_data); end
    tick();
    accept_op(32'h1000_0000, 5'd4, 3'b010, 2'b01, 1'b1, 1'b1);
    pulse_ok(32'h8001_7FFF);
    n_checks++; if (bus.wb_data !== 32'h8001_7FFF) begin n_fail++; $display("FAIL lw got %h want 80017fff", bus.wb_data); end
    tick();
    accept_op(32'h2000_0004, 5'd9, 3'b010, 2'b10, 1'b0, 1'b0);
    pulse_ok(32'h1111_2222);
    n_checks++; if (bus.wb_data !== 32'h2000_0004) begin n_fail++; $display("FAIL store_data got %h want 20000004", bus.wb_data); end
    n_checks++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL store_wb_en got %b want 0", bus.wb_en); end
    tick();
    accept_op(32'h3000_0000, 5'd7, 3'b010, 2'b01, 1'b1, 1'b0);
    pulse_ok(32'hFFFF_FFFF);
    n_checks++; if (bus.wb_data !== 32'h3000_0000) begin n_fail++; $display("FAIL load_src0 got %h want 30000000", bus.wb_data); end
    tick();
  endtask

  task automatic test_stall();
    bus.wb_ready = 1'b0;
    accept_op(32'h0000_00AA, 5'd10, 3'b010, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h0000_00AA || bus.wb_rd_index !== 5'd10)
        begin n_fail++; $display("FAIL stall_hold cyc %0d got v=%b d=%h rd=%0d want 1/000000aa/10", i, bus.wb_valid, bus.wb_data, bus.wb_rd_index); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cyc %0d got %b want 0", i, bus.in_ready); end
      tick();
    end
    bus.wb_ready = 1'b1;
    set_op(32'h0000_00BB, 5'd11, 3'b010, 2'b00, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_in_ready got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.wb_data !== 32'h0000_00BB || bus.wb_rd_index !== 5'd11)
      begin n_fail++; $display("FAIL stall_next got d=%h rd=%0d want 000000bb/11", bus.wb_data, bus.wb_rd_index); end
    tick();
  endtask

  task automatic test_flush();
    accept_op(32'h1000_0000, 5'd12, 3'b010, 2'b01, 1'b1, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0 || bus.wb_valid !== 1'b0)
      begin n_fail++; $display("FAIL drain got rdy=%b v=%b want 0/0", bus.in_ready, bus.wb_valid); end
    tick();
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_hold_rdy got %b want 0", bus.in_ready); end
    pulse_ok(32'hDEAD_BEEF);
    n_checks++; if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin n_fail++; $display("FAIL drain_exit got v=%b rdy=%b want 0/1", bus.wb_valid, bus.in_ready); end
    accept_op(32'h1000_0000, 5'd12, 3'b010, 2'b01, 1'b1, 1'b1);
    bus.flush          = 1'b1;
    bus.dcache_data_ok = 1'b1;
    bus.dcache_rdata   = 32'hDEAD_BEEF;
    tick();
    bus.flush          = 1'b0;
    bus.dcache_data_ok = 1'b0;
    #1;
    n_checks++; if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin n_fail++; $display("FAIL flush_ok got v=%b rdy=%b want 0/1", bus.wb_valid, bus.in_ready); end
    bus.flush = 1'b1;
    set_op(32'h0000_0055, 5'd13, 3'b010, 2'b00, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_idle_rdy got %b want 0", bus.in_ready); end
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle_noaccept got %b want 0", bus.wb_valid); end
  endtask

  task automatic test_rd0_and_reset();
    accept_op(32'h1000_0000, 5'd0, 3'b010, 2'b01, 1'b1, 1'b1);
    pulse_ok(32'h1234_0000);
    n_checks++; if (bus.wb_valid !== 1'b1 || bus.wb_en !== 1'b0)
      begin n_fail++; $display("FAIL rd0 got v=%b en=%b want 1/0", bus.wb_valid, bus.wb_en); end
    tick();
    accept_op(32'h1000_0000, 5'd14, 3'b010, 2'b01, 1'b1, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    n_checks++; if (bus.wb_valid !== 1'b0 || bus.wb_en !== 1'b0 || bus.wb_rd_index !== 5'd0 || bus.wb_data !== 32'h0)
      begin n_fail++; $display("FAIL midreset_outs got v=%b en=%b rd=%0d d=%h want zeros", bus.wb_valid, bus.wb_en, bus.wb_rd_index, bus.wb_data); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_rdy got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    pulse_ok(32'hCAFE_F00D);
    n_checks++; if (bus.wb_valid !== 1'b0 || bus.wb_data !== 32'h0)
      begin n_fail++; $display("FAIL late_ok got v=%b d=%h want 0/0", bus.wb_valid, bus.wb_data); end
  endtask

  initial begin
    n_checks                 = 0;
    n_fail                   = 0;
    rst                      = 1'b1;
    bus.flush                = 1'b0;
    bus.in_valid             = 1'b0;
    bus.ex_result_pass       = '0;
    bus.rd_index_pass        = '0;
    bus.number_length_pass   = '0;
    bus.memory_rw_pass       = '0;
    bus.writeback_valid_pass = 1'b0;
    bus.writeback_src_pass   = 1'b0;
    bus.dcache_data_ok       = 1'b0;
    bus.dcache_rdata         = '0;
    bus.wb_ready             = 1'b1;
    test_reset();
    test_alu();
    test_load_byte();
    test_load_half_word();
    test_stall();
    test_flush();
    test_rd0_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory2_stage.md
Name: memory2_stage

Overview:
- Second memory pipeline stage of the in-order core, directly downstream of the Memory1 stage.
- Holds the Memory1→Memory2 segment register and waits for the data-cache response to a load or store issued by Memory1.
- Extracts and extends load data according to number_length and selects the writeback source.
- Presents a registered result to the Writeback stage under a valid/ready handshake.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  kill the stage contents (exception/branch redirect)
in_valid  input  1  Memory1 presents an instruction
in_ready  output  1  stage can accept this cycle
ex_result_pass  input  32  ALU result / memory address from Memory1
rd_index_pass  input  5  destination register
number_length_pass  input  3  [1:0] size: 00 byte, 01 half, 10 word; [2]=1 zero-extend, 0 sign-extend
memory_rw_pass  input  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
writeback_valid_pass  input  1  instruction writes rd
writeback_src_pass  input  1  0 = ex_result, 1 = load data
dcache_data_ok  input  1  one-cycle pulse: response for the outstanding access
dcache_rdata  input  32  load word, valid with dcache_data_ok
wb_valid  output  1  result valid to Writeback
wb_ready  input  1  Writeback accepts
wb_en  output  1  register-file write enable
wb_rd_index  output  5  destination register
wb_data  output  32  write data

Behaviour:
- States: IDLE (empty), WAIT (memory access outstanding), DONE (result held), DRAIN (flushed access still outstanding).
- Reset: state IDLE; wb_valid, wb_en, wb_rd_index, wb_data and all internal registers are 0. in_ready=1 after reset.
- in_ready = (IDLE) or (DONE and wb_ready); forced 0 when flush=1. Accept when in_valid and in_ready.
- On accept: all inputs are latched.
  - memory_rw 00/11: next state DONE with wb_data=ex_result.
  - Load or store: next state WAIT.
- DONE with wb_ready=1 and no accept: next state IDLE.
- DONE with wb_ready=1 and a simultaneous accept: back-to-back transfer, zero bubbles.
- WAIT: dcache_data_ok is sampled only in WAIT; the earliest response is the cycle after accept. When it is seen, next state DONE.
  - Load: wb_data = formatted load.
  - Store: wb_data = ex_result.
  - Without dcache_data_ok, WAIT holds indefinitely with in_ready=0.
- DONE outputs:
  - wb_valid=1.
  - wb_en = writeback_valid and (rd_index != 0).
  - wb_rd_index = latched rd_index.
  - All three are stable until the handshake completes.
- Load formatting (registered, off = ex_result[1:0]):
  - Byte: byte lane off of dcache_rdata.
  - Half: lane ex_result[1] (bits 31:16 if 1, else 15:0); ex_result[0] is ignored, since misalignment is trapped upstream.
  - Word: dcache_rdata unchanged; off is ignored.
  - Size 11: treated as word.
  - Extension: bit2=0 sign-extends the selected MSB to 32 bits; bit2=1 zero-extends.
  - writeback_src=0 on a load: wb_data=ex_result. The response is still awaited.
- flush (highest priority, same edge):
  - IDLE/DONE: next IDLE, wb_valid=0. No accept that cycle even if in_valid=1.
  - WAIT without dcache_data_ok: next DRAIN.
  - WAIT with dcache_data_ok the same cycle: response discarded, next IDLE.
  - DRAIN: in_ready=0 and wb_valid=0; next dcache_data_ok is discarded and the next state is IDLE. A flush while in DRAIN stays in DRAIN.
- wb_valid is 0 in IDLE, WAIT and DRAIN. wb_en is 0 whenever wb_valid is 0.
- Reset asserted mid-operation returns to IDLE immediately. An outstanding response arriving after reset is ignored in IDLE.

Test Plan:
- ALU op: accept ex_result=0x1234_5678, rd=5, wb_valid_in=1, rw=00, wb_ready=1 → next cycle wb_valid=1, wb_en=1, wb_rd_index=5, wb_data=0x1234_5678; in_ready stays 1; back-to-back second op issues with no bubble.
- Load byte signed: ex_result=0x1000_0003, len=000, dcache_rdata=0x80FF_0102, data_ok 2 cycles after accept → in_ready=0 while waiting; then wb_data=0xFFFF_FF80. Same with len=100 → 0x0000_0080.
- Load half: ex_result[1]=1, len=001, rdata=0x8001_7FFF → 0xFFFF_8001. ex_result[1]=0, len=101 → 0x0000_7FFF. Word len=010 → 0x8001_7FFF.
- Writeback stall: DONE with wb_ready=0 for 3 cycles → wb_valid, wb_data and wb_rd_index stable, in_ready=0; wb_ready=1 with in_valid=1 → transfer and accept in the same cycle.
- Flush during WAIT: load accepted, flush=1 before data_ok → DRAIN, in_ready=0; data_ok with rdata=0xDEAD_BEEF → no wb_valid, IDLE. Flush coinciding with data_ok → IDLE directly, nothing written.
- rd=0 and reset: load to rd=0 → wb_valid=1, wb_en=0. Assert rst during WAIT → all outputs 0, in_ready=1; a later data_ok produces nothing.
